// File: rtl/keccak_drv_pkg.sv
// Shared constants and FSM encoding for the Keccak-200 port-serial driver.
// The optional RUN timeout is enabled by defining KECCAK_DRV_TIMEOUT_EN.
package keccak_drv_pkg;

  localparam int DRV_STATE_W = 200;
  localparam int DRV_BYTE_W  = 8;
  localparam int DRV_NBYTES  = DRV_STATE_W / DRV_BYTE_W;
  localparam int DRV_TMO_CYC = 255;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_RUN    = 3'd2,
    ST_UNLOAD = 3'd3,
    ST_DONE   = 3'd4
  } drv_state_e;

  function automatic logic is_busy_state(input drv_state_e s);
    return (s == ST_LOAD) || (s == ST_RUN) || (s == ST_UNLOAD);
  endfunction

  // The core only permutes while its reset is low, i.e. during RUN and UNLOAD.
  function automatic logic core_hold_state(input drv_state_e s);
    return !((s == ST_RUN) || (s == ST_UNLOAD));
  endfunction

endpackage

// File: rtl/keccak_byte_shifter.sv
// State register with parallel load, byte-indexed read and byte-indexed write.
// data_nxt exposes the value the register takes at the next edge.
module keccak_byte_shifter
  import keccak_drv_pkg::*;
#(
  parameter int STATE_W = DRV_STATE_W,
  parameter int BYTE_W  = DRV_BYTE_W,
  parameter int NBYTES  = STATE_W / BYTE_W,
  parameter int IDX_W   = $clog2(NBYTES)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_en,
  input  logic [STATE_W-1:0] load_data,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic [BYTE_W-1:0]  wr_byte,
  input  logic [IDX_W-1:0]   rd_idx,
  output logic [BYTE_W-1:0]  rd_byte,
  output logic [STATE_W-1:0] data_nxt
);

  logic [STATE_W-1:0] data_q;
  logic [STATE_W-1:0] data_d;

  // Next-state: parallel load wins over a single-byte write.
  always_comb begin
    data_d = data_q;
    for (int i = 0; i < NBYTES; i++) begin
      data_d[i*BYTE_W +: BYTE_W] = load_en ? load_data[i*BYTE_W +: BYTE_W] :
                                   (wr_en && (wr_idx == IDX_W'(i))) ? wr_byte :
                                   data_q[i*BYTE_W +: BYTE_W];
    end
  end

  // Byte read mux built as an AND-OR tree over all byte lanes.
  always_comb begin
    rd_byte = {BYTE_W{1'b0}};
    for (int i = 0; i < NBYTES; i++) begin
      rd_byte = rd_byte | (data_q[i*BYTE_W +: BYTE_W] & {BYTE_W{rd_idx == IDX_W'(i)}});
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= {STATE_W{1'b0}};
    end else begin
      data_q <= data_d;
    end
  end

  assign data_nxt = data_d;

endmodule

// File: rtl/keccak_port_serial_driver.sv
// Host-side initiator for the byte-serial Keccak-200 core: LOAD, RUN, UNLOAD, DONE.
// Define KECCAK_DRV_TIMEOUT_EN to bound the RUN wait and raise a sticky TimeoutErr.
module keccak_port_serial_driver
  import keccak_drv_pkg::*;
#(
  parameter int STATE_W = DRV_STATE_W,
  parameter int BYTE_W  = DRV_BYTE_W,
  parameter int NBYTES  = STATE_W / BYTE_W
`ifdef KECCAK_DRV_TIMEOUT_EN
  , parameter int TMO_CYC = DRV_TMO_CYC
`endif
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               InValid,
  output logic               InReady,
  input  logic [STATE_W-1:0] InState,
  output logic               OutValid,
  input  logic               OutReady,
  output logic [STATE_W-1:0] OutState,
  output logic               Busy,
  output logic               CoreReset,
  output logic [BYTE_W-1:0]  CoreIn,
  input  logic               CoreReady,
  input  logic [BYTE_W-1:0]  CoreOut,
  output logic               TimeoutErr
);

  localparam int IDX_W = $clog2(NBYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  drv_state_e         state_q, state_d;
  logic [IDX_W-1:0]   cnt_q, cnt_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;
  logic               core_reset_q, core_reset_d;
  logic [BYTE_W-1:0]  core_in_q, core_in_d;
  logic [STATE_W-1:0] out_state_q, out_state_d;

  logic               sh_load;
  logic               sh_wr;
  logic [IDX_W-1:0]   sh_wr_idx;
  logic [BYTE_W-1:0]  sh_rd_byte;
  logic [STATE_W-1:0] sh_nxt;
  logic               tmo_hit;

  keccak_byte_shifter #(
    .STATE_W (STATE_W),
    .BYTE_W  (BYTE_W),
    .NBYTES  (NBYTES),
    .IDX_W   (IDX_W)
  ) u_shifter (
    .clk       (Clock),
    .rst       (Reset),
    .load_en   (sh_load),
    .load_data (InState),
    .wr_en     (sh_wr),
    .wr_idx    (sh_wr_idx),
    .wr_byte   (CoreOut),
    .rd_idx    (cnt_d),
    .rd_byte   (sh_rd_byte),
    .data_nxt  (sh_nxt)
  );

  // Next-state logic, byte counter and shifter control.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sh_load     = 1'b0;
    sh_wr       = 1'b0;
    sh_wr_idx   = cnt_q;
    out_state_d = out_state_q;
    case (state_q)
      ST_IDLE: begin
        if (InValid && in_ready_q) begin
          sh_load = 1'b1;
          state_d = ST_LOAD;
          cnt_d   = {IDX_W{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (cnt_q == LAST_IDX) begin
          state_d = ST_RUN;
          cnt_d   = {IDX_W{1'b0}};
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        // The byte presented alongside the first Ready is already byte 0.
        if (CoreReady) begin
          sh_wr     = 1'b1;
          sh_wr_idx = {IDX_W{1'b0}};
          state_d   = ST_UNLOAD;
          cnt_d     = IDX_W'(1);
        end else if (tmo_hit) begin
          state_d = ST_IDLE;
          cnt_d   = {IDX_W{1'b0}};
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_UNLOAD: begin
        sh_wr = 1'b1;
        if (cnt_q == LAST_IDX) begin
          state_d     = ST_DONE;
          cnt_d       = {IDX_W{1'b0}};
          out_state_d = sh_nxt;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (OutReady) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = {IDX_W{1'b0}};
      end
    endcase
  end

  // Registered outputs are decoded from the next state so they line up with it.
  always_comb begin
    in_ready_d   = (state_d == ST_IDLE);
    out_valid_d  = (state_d == ST_DONE);
    busy_d       = is_busy_state(state_d);
    core_reset_d = core_hold_state(state_d);
    if (sh_load) begin
      core_in_d = InState[BYTE_W-1:0];
    end else if (state_d == ST_LOAD) begin
      core_in_d = sh_rd_byte;
    end else begin
      core_in_d = {BYTE_W{1'b0}};
    end
  end

  // FSM and output registers.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= {IDX_W{1'b0}};
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      core_reset_q <= 1'b1;
      core_in_q    <= {BYTE_W{1'b0}};
      out_state_q  <= {STATE_W{1'b0}};
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      busy_q       <= busy_d;
      core_reset_q <= core_reset_d;
      core_in_q    <= core_in_d;
      out_state_q  <= out_state_d;
    end
  end

`ifdef KECCAK_DRV_TIMEOUT_EN
  localparam int TMO_W = $clog2(TMO_CYC + 1);

  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             tmo_err_q, tmo_err_d;

  // RUN cycle counter; cleared whenever the FSM is not waiting on the core.
  always_comb begin
    if ((state_q == ST_RUN) && !CoreReady) begin
      tmo_hit   = (tmo_cnt_q == TMO_W'(TMO_CYC - 1));
      tmo_cnt_d = tmo_cnt_q + 1'b1;
    end else begin
      tmo_hit   = 1'b0;
      tmo_cnt_d = {TMO_W{1'b0}};
    end
    tmo_err_d = tmo_err_q | tmo_hit;
  end

  // Timeout counter and sticky error flag.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      tmo_cnt_q <= {TMO_W{1'b0}};
      tmo_err_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      tmo_err_q <= tmo_err_d;
    end
  end

  assign TimeoutErr = tmo_err_q;
`else
  assign tmo_hit    = 1'b0;
  assign TimeoutErr = 1'b0;
`endif

  assign InReady   = in_ready_q;
  assign OutValid  = out_valid_q;
  assign OutState  = out_state_q;
  assign Busy      = busy_q;
  assign CoreReset = core_reset_q;
  assign CoreIn    = core_in_q;

endmodule

// File: tb/tb_keccak_port_serial_driver.sv
// Directed bench for keccak_port_serial_driver with a behavioural byte-serial core model.
// The model returns the known KAT answer for the KAT input and an inverted byte-rotation otherwise.
module tb_keccak_port_serial_driver;

  localparam logic [199:0] KAT_IN  = {128'hffffffffffffffffffffffffffffffff, 72'h0123456789abcdef01};
  localparam logic [199:0] KAT_OUT = 200'he090c8c5e596d3421d2fcc695838626cbb365352811837480f;
  localparam logic [199:0] P2_IN   = 200'h18171615_14131211_100f0e0d_0c0b0a09_08070605_04030201_00;
  localparam logic [199:0] P2_OUT  = 200'hffe7e8e9_eaebeced_eeeff0f1_f2f3f4f5_f6f7f8f9_fafbfcfd_fe;
  localparam int CORE_LAT = 5;

  logic         Clock = 1'b0;
  logic         Reset;
  logic         InValid;
  logic         InReady;
  logic [199:0] InState;
  logic         OutValid;
  logic         OutReady;
  logic [199:0] OutState;
  logic         Busy;
  logic         CoreReset;
  logic [7:0]   CoreIn;
  logic         CoreReady;
  logic [7:0]   CoreOut;
  logic         TimeoutErr;

  keccak_port_serial_driver dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .InValid    (InValid),
    .InReady    (InReady),
    .InState    (InState),
    .OutValid   (OutValid),
    .OutReady   (OutReady),
    .OutState   (OutState),
    .Busy       (Busy),
    .CoreReset  (CoreReset),
    .CoreIn     (CoreIn),
    .CoreReady  (CoreReady),
    .CoreOut    (CoreOut),
    .TimeoutErr (TimeoutErr)
  );

  always #5 Clock = ~Clock;

  // Core model: shifts bytes in while held in reset, answers CORE_LAT cycles after release.
  logic [199:0] m_ld = 200'h0;
  logic [199:0] m_res = 200'h0;
  int           m_run = 0;
  int           m_idx = 0;
  logic         m_rdy = 1'b0;
  logic         hang = 1'b0;
  logic         spur_rdy = 1'b0;

  function automatic logic [199:0] core_fn(input logic [199:0] x);
    if (x == KAT_IN) return KAT_OUT;
    return ~{x[7:0], x[199:8]};
  endfunction

  always @(posedge Clock) begin
    if (CoreReset) begin
      m_ld  <= {CoreIn, m_ld[199:8]};
      m_run <= 0;
      m_rdy <= 1'b0;
      m_idx <= 0;
    end else if (!m_rdy) begin
      m_run <= m_run + 1;
      if (!hang && (m_run == CORE_LAT - 1)) begin
        m_rdy <= 1'b1;
        m_res <= core_fn(m_ld);
      end
    end else if (m_idx < 24) begin
      m_idx <= m_idx + 1;
    end
  end

  assign CoreOut   = m_rdy ? m_res[m_idx*8 +: 8] : 8'h00;
  assign CoreReady = m_rdy | spur_rdy;

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [199:0] obs, input logic [199:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int           cyc;
  logic         seen;
  logic         hold_ok;
  logic [199:0] kat_v;

  initial begin
    Reset = 1'b1; InValid = 1'b0; InState = 200'h0; OutReady = 1'b0;
    kat_v = KAT_IN;
    repeat (3) @(negedge Clock);
    chk("rst_in_ready", InReady, 1'b0);
    chk("rst_out_valid", OutValid, 1'b0);
    chk("rst_busy", Busy, 1'b0);
    chk("rst_core_reset", CoreReset, 1'b1);
    chk("rst_core_in", CoreIn, 8'h00);
    chk("rst_out_state", OutState, 200'h0);
    chk("rst_timeout", TimeoutErr, 1'b0);
    Reset = 1'b0;
    @(negedge Clock);
    chk("idle_in_ready", InReady, 1'b1);
    chk("idle_busy", Busy, 1'b0);

    // KAT with byte-level protocol check during LOAD
    InState = KAT_IN; InValid = 1'b1;
    @(negedge Clock);
    InValid = 1'b0; InState = 200'h0;
    for (int k = 0; k < 25; k++) begin
      if (k > 0) @(negedge Clock);
      chk($sformatf("load_core_reset%0d", k), CoreReset, 1'b1);
      chk($sformatf("load_byte%0d", k), CoreIn, kat_v[k*8 +: 8]);
    end
    chk("load_busy", Busy, 1'b1);
    @(negedge Clock);
    cyc = 25;
    chk("run_core_reset", CoreReset, 1'b0);
    chk("run_core_in", CoreIn, 8'h00);
    chk("run_busy", Busy, 1'b1);
    while (!OutValid && cyc < 400) begin
      @(negedge Clock);
      cyc++;
    end
    chk("kat_latency", cyc, 55);
    chk("kat_out_state", OutState, KAT_OUT);
    chk("done_busy", Busy, 1'b0);
    chk("done_in_ready", InReady, 1'b0);

    // Backpressure: result must hold while OutReady stays low
    hold_ok = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge Clock);
      if (!(OutValid === 1'b1 && OutState === KAT_OUT && InReady === 1'b0)) hold_ok = 1'b0;
    end
    chk("backpressure_hold", hold_ok, 1'b1);
    OutReady = 1'b1; InValid = 1'b1; InState = P2_IN;
    @(negedge Clock);
    OutReady = 1'b0;
    chk("accept_out_valid", OutValid, 1'b0);
    chk("accept_in_ready", InReady, 1'b1);
    chk("accept_no_take", Busy, 1'b0);
    chk("accept_keep_state", OutState, KAT_OUT);

    // Second pattern, now taken, with a spurious Ready pulse during LOAD
    @(negedge Clock);
    InValid = 1'b0;
    chk("p2_busy", Busy, 1'b1);
    repeat (2) @(negedge Clock);
    spur_rdy = 1'b1;
    repeat (2) @(negedge Clock);
    spur_rdy = 1'b0;
    cyc = 0;
    while (!OutValid && cyc < 400) begin
      @(negedge Clock);
      cyc++;
    end
    chk("p2_out_valid", OutValid, 1'b1);
    chk("p2_out_state", OutState, P2_OUT);
    OutReady = 1'b1;
    @(negedge Clock);
    OutReady = 1'b0;
    chk("p2_keep_state", OutState, P2_OUT);
    chk("p2_out_valid_drop", OutValid, 1'b0);

    // Reset mid-UNLOAD after byte 10 has been captured
    InState = KAT_IN; InValid = 1'b1;
    @(negedge Clock);
    InValid = 1'b0;
    cyc = 0; seen = 1'b0;
    while (cyc < 41) begin
      @(negedge Clock);
      cyc++;
      seen = seen | OutValid;
    end
    chk("mid_unload_busy", Busy, 1'b1);
    chk("mid_unload_core_reset", CoreReset, 1'b0);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    chk("abort_busy", Busy, 1'b0);
    chk("abort_core_reset", CoreReset, 1'b1);
    chk("abort_out_state", OutState, 200'h0);
    for (int i = 0; i < 60; i++) begin
      @(negedge Clock);
      seen = seen | OutValid;
    end
    chk("abort_no_out_valid", seen, 1'b0);
    chk("abort_in_ready", InReady, 1'b1);

    // Rerun of the KAT after the abort
    InState = KAT_IN; InValid = 1'b1;
    @(negedge Clock);
    InValid = 1'b0;
    cyc = 0;
    while (!OutValid && cyc < 400) begin
      @(negedge Clock);
      cyc++;
    end
    chk("rerun_latency", cyc, 55);
    chk("rerun_out_state", OutState, KAT_OUT);
    OutReady = 1'b1;
    @(negedge Clock);
    OutReady = 1'b0;
    chk("rerun_timeout_clear", TimeoutErr, 1'b0);

`ifdef KECCAK_DRV_TIMEOUT_EN
    // Core never answers: RUN gives up after 255 cycles
    hang = 1'b1;
    InState = P2_IN; InValid = 1'b1;
    @(negedge Clock);
    InValid = 1'b0;
    cyc = 0;
    while (cyc < 279) begin
      @(negedge Clock);
      cyc++;
    end
    chk("tmo_before", TimeoutErr, 1'b0);
    chk("tmo_before_busy", Busy, 1'b1);
    @(negedge Clock);
    chk("tmo_flag", TimeoutErr, 1'b1);
    chk("tmo_busy", Busy, 1'b0);
    chk("tmo_core_reset", CoreReset, 1'b1);
    chk("tmo_out_valid", OutValid, 1'b0);
    repeat (10) @(negedge Clock);
    chk("tmo_sticky", TimeoutErr, 1'b1);
    chk("tmo_in_ready", InReady, 1'b1);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    chk("tmo_cleared", TimeoutErr, 1'b0);
    hang = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
